ne_fp_norm_ctrl: RTL

Multi-cycle normalization controller for the dot-product accumulator output path. It accepts an unnormalized 33-bit magnitude and biased exponent over a valid/ready handshake and counts leading zeros. It then sequences one shared left-shift block to bring the MSB to bit 32, adjusts the exponent, and presents the result over a second valid/ready handshake. Denormal clamping and zero detection are handled here, so downstream rounding sees only normalized, denormal, or zero operands.

---
 rtl/ne_fp_pkg.sv | 15 +
 rtl/ne_fp_sfl_blk_w33s6.sv | 26 ++
 rtl/ne_fp_norm_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ne_fp_pkg.sv
// Shared types and default widths for the ne_fp normalization path.
package ne_fp_pkg;

    localparam int NE_BW_MAN = 33;
    localparam int NE_BW_SF  = 6;
    localparam int NE_BW_EXP = 10;

    typedef enum logic [1:0] {
        NE_NORM_IDLE  = 2'd0,
        NE_NORM_LZC   = 2'd1,
        NE_NORM_SHIFT = 2'd2,
        NE_NORM_OUT   = 2'd3
    } ne_norm_state_e;

endpackage

// File: rtl/ne_fp_sfl_blk_w33s6.sv
// Shared combinational left shifter; SIGNED keeps the sign bit, otherwise plain zero-fill shift.
module ne_fp_sfl_blk_w33s6
    import ne_fp_pkg::*;
#(
    parameter int BW_DATA = NE_BW_MAN,
    parameter int BW_SF   = NE_BW_SF,
    parameter bit SIGNED  = 1'b0
) (
    input  logic [BW_DATA-1:0] i_a,
    input  logic [BW_SF-1:0]   i_s,
    output logic [BW_DATA-1:0] o_z
);

    logic [BW_DATA-1:0] w_shl;

    assign w_shl = i_a << i_s;

    generate
        if (SIGNED) begin : g_signed
            assign o_z = {i_a[BW_DATA-1], w_shl[BW_DATA-2:0]};
        end else begin : g_unsigned
            assign o_z = w_shl;
        end
    endgenerate

endmodule

// File: rtl/ne_fp_norm_ctrl.sv
// Multi-cycle normalizer: leading-zero count, exponent-clamped left shift, result handshake.
module ne_fp_norm_ctrl
    import ne_fp_pkg::*;
#(
    parameter int BW_DATA = NE_BW_MAN,
    parameter int BW_SF   = NE_BW_SF,
    parameter int BW_EXP  = NE_BW_EXP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [BW_DATA-1:0] in_man,
    input  logic [BW_EXP-1:0]  in_exp,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [BW_DATA-1:0] out_man,
    output logic [BW_EXP-1:0]  out_exp,
    output logic               out_zero,
    output logic               out_uf,
    output logic               busy
);

    ne_norm_state_e     r_state;
    logic [BW_DATA-1:0] r_man;
    logic [BW_EXP-1:0]  r_exp;
    logic [BW_SF-1:0]   r_sh;
    logic               r_zero;
    logic               r_uf;
    logic [BW_DATA-1:0] r_man_o;
    logic [BW_EXP-1:0]  r_exp_o;
    logic               r_zero_o;
    logic               r_uf_o;
    logic               r_in_rdy;
    logic               r_out_vld;
    logic               r_busy;

    logic [BW_SF-1:0]   w_lz;
    logic               w_lz_gt_exp;
    logic [BW_SF-1:0]   w_sh;
    logic [BW_DATA-1:0] w_shl;

    // NOTE: w_lz gets a default before the scan so the block never holds a value (no latch).
    always_comb begin
        w_lz = BW_SF'(BW_DATA);
        for (int i = 0; i < BW_DATA; i++) begin
            if (r_man[i]) w_lz = BW_SF'(BW_DATA - 1 - i);
        end
    end

    // Shift is limited to the exponent so the result never needs a negative exponent.
    assign w_lz_gt_exp = BW_EXP'(w_lz) > r_exp;
    assign w_sh        = w_lz_gt_exp ? r_exp[BW_SF-1:0] : w_lz;

    ne_fp_sfl_blk_w33s6 #(
        .BW_DATA (BW_DATA),
        .BW_SF   (BW_SF),
        .SIGNED  (1'b0)
    ) u_sfl (
        .i_a (r_man),
        .i_s (r_sh),
        .o_z (w_shl)
    );

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= NE_NORM_IDLE;
            r_man     <= '0;
            r_exp     <= '0;
            r_sh      <= '0;
            r_zero    <= 1'b0;
            r_uf      <= 1'b0;
            r_man_o   <= '0;
            r_exp_o   <= '0;
            r_zero_o  <= 1'b0;
            r_uf_o    <= 1'b0;
            r_in_rdy  <= 1'b1;
            r_out_vld <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                NE_NORM_IDLE: begin
                    if (in_vld && r_in_rdy) begin
                        r_man    <= in_man;
                        r_exp    <= in_exp;
                        r_in_rdy <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= NE_NORM_LZC;
                    end
                end
                NE_NORM_LZC: begin
                    r_sh    <= w_sh;
                    r_zero  <= (r_man == '0);
                    r_uf    <= (r_man != '0) && w_lz_gt_exp;
                    r_state <= NE_NORM_SHIFT;
                end
                NE_NORM_SHIFT: begin
                    if (r_zero) begin
                        r_man_o <= '0;
                        r_exp_o <= '0;
                    end else begin
                        r_man_o <= w_shl;
                        r_exp_o <= r_exp - BW_EXP'(r_sh);
                    end
                    r_zero_o  <= r_zero;
                    r_uf_o    <= r_uf;
                    r_out_vld <= 1'b1;
                    r_state   <= NE_NORM_OUT;
                end
                NE_NORM_OUT: begin
                    if (out_rdy) begin
                        r_out_vld <= 1'b0;
                        r_in_rdy  <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= NE_NORM_IDLE;
                    end
                end
                default: begin
                    r_in_rdy  <= 1'b1;
                    r_out_vld <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= NE_NORM_IDLE;
                end
            endcase
        end
    end

    assign in_rdy   = r_in_rdy;
    assign out_vld  = r_out_vld;
    assign out_man  = r_man_o;
    assign out_exp  = r_exp_o;
    assign out_zero = r_zero_o;
    assign out_uf   = r_uf_o;
    assign busy     = r_busy;

endmodule
